// File: rtl/uarch_pkg.sv
// Core-wide micro-architecture widths shared by the front-end blocks.
package uarch_pkg;
    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_INST_BITS = 32;
endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side signal bundle of the instruction buffer.
// master = the pipeline around the buffer, slave = the buffer itself.
interface inst_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int AW    = uarch_pkg::CPU_ADDR_BITS;
    localparam int IW    = uarch_pkg::CPU_INST_BITS;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             fetch_inst0_val;
    logic             fetch_inst1_val;
    logic [AW-1:0]    fetch_inst0_pc;
    logic [AW-1:0]    fetch_inst1_pc;
    logic [IW-1:0]    fetch_inst0;
    logic [IW-1:0]    fetch_inst1;
    logic             ibuf_rdy;
    logic             decode_rdy;
    logic [AW-1:0]    inst0_pc;
    logic [AW-1:0]    inst1_pc;
    logic [IW-1:0]    inst0;
    logic [IW-1:0]    inst1;
    logic             inst_val;
    logic [CNT_W-1:0] ibuf_count;

    modport master (
        output flush, fetch_inst0_val, fetch_inst1_val,
               fetch_inst0_pc, fetch_inst1_pc, fetch_inst0, fetch_inst1,
               decode_rdy,
        input  ibuf_rdy, inst0_pc, inst1_pc, inst0, inst1, inst_val, ibuf_count
    );

    modport slave (
        input  flush, fetch_inst0_val, fetch_inst1_val,
               fetch_inst0_pc, fetch_inst1_pc, fetch_inst0, fetch_inst1,
               decode_rdy,
        output ibuf_rdy, inst0_pc, inst1_pc, inst0, inst1, inst_val, ibuf_count
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular fetch-to-decode instruction queue: up to two writes and two
// in-order reads per cycle, single-instruction pairs padded with a zero word.
module inst_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_buffer_if.slave bus
);
    localparam int AW    = uarch_pkg::CPU_ADDR_BITS;
    localparam int IW    = uarch_pkg::CPU_INST_BITS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    logic [AW-1:0]    entry_pc_q   [DEPTH];
    logic [IW-1:0]    entry_inst_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] deq_n;
    logic             ibuf_rdy;
    logic             inst_val;
    logic             enq_fire;
    logic             wr_slot1;
    logic             deq_fire;

    logic [AW-1:0]    out_pc0;
    logic [AW-1:0]    out_pc1;
    logic [IW-1:0]    out_inst0;
    logic [IW-1:0]    out_inst1;

    assign head_p1    = head_q + PTR_W'(1);
    assign tail_p1    = tail_q + PTR_W'(1);
    assign free_slots = DEPTH_C - count_q;
    // Ready looks only at registered occupancy so fetch never depends on decode_rdy.
    assign ibuf_rdy   = (free_slots >= TWO_C);
    assign inst_val   = (count_q != '0);

    always_comb begin
        enq_fire = ibuf_rdy && bus.fetch_inst0_val && !bus.flush;
        wr_slot1 = enq_fire && bus.fetch_inst1_val;
        enq_n    = '0;
        if (enq_fire) begin
            enq_n = wr_slot1 ? TWO_C : ONE_C;
        end

        deq_fire = inst_val && bus.decode_rdy && !bus.flush;
        deq_n    = '0;
        if (deq_fire) begin
            deq_n = (count_q >= TWO_C) ? TWO_C : ONE_C;
        end

        head_d  = head_q + deq_n[PTR_W-1:0];
        tail_d  = tail_q + enq_n[PTR_W-1:0];
        count_d = count_q + enq_n - deq_n;

        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            entry_pc_q[tail_q]   <= bus.fetch_inst0_pc;
            entry_inst_q[tail_q] <= bus.fetch_inst0;
        end
        if (wr_slot1) begin
            entry_pc_q[tail_p1]   <= bus.fetch_inst1_pc;
            entry_inst_q[tail_p1] <= bus.fetch_inst1;
        end
    end

    always_comb begin
        out_pc0   = '0;
        out_pc1   = '0;
        out_inst0 = '0;
        out_inst1 = '0;
        if (count_q != '0) begin
            out_pc0   = entry_pc_q[head_q];
            out_inst0 = entry_inst_q[head_q];
            if (count_q >= TWO_C) begin
                out_pc1   = entry_pc_q[head_p1];
                out_inst1 = entry_inst_q[head_p1];
            end else begin
                out_pc1   = entry_pc_q[head_q] + AW'(4);
            end
        end
    end

    assign bus.ibuf_rdy   = ibuf_rdy;
    assign bus.inst_val   = inst_val;
    assign bus.ibuf_count = count_q;
    assign bus.inst0_pc   = out_pc0;
    assign bus.inst1_pc   = out_pc1;
    assign bus.inst0      = out_inst0;
    assign bus.inst1      = out_inst1;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: reference queue scoreboard, a table of
// fill/drain vectors and hand-written corner-case sequences.
module tb_inst_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        drdy;
        int          exp_count;
        logic        exp_rdy;
        logic [31:0] exp_pc0;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    entry_t model_q[$];

    inst_buffer_if #(.DEPTH(DEPTH)) bus();

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[19:0], 12'h093};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Compare the presented outputs against the front of the reference queue.
    task automatic check_output();
        int          n;
        logic [31:0] e_pc0, e_pc1, e_i0, e_i1;
        n     = model_q.size();
        e_pc0 = 0; e_pc1 = 0; e_i0 = 0; e_i1 = 0;
        if (n >= 1) begin
            e_pc0 = model_q[0].pc;
            e_i0  = model_q[0].inst;
            e_pc1 = model_q[0].pc + 32'd4;
        end
        if (n >= 2) begin
            e_pc1 = model_q[1].pc;
            e_i1  = model_q[1].inst;
        end
        check("inst_val",   {31'd0, bus.inst_val}, {31'd0, n != 0});
        check("ibuf_rdy",   {31'd0, bus.ibuf_rdy}, {31'd0, (DEPTH - n) >= 2});
        check("ibuf_count", {28'd0, bus.ibuf_count}, n);
        check("inst0_pc",   bus.inst0_pc, e_pc0);
        check("inst0",      bus.inst0,    e_i0);
        check("inst1_pc",   bus.inst1_pc, e_pc1);
        check("inst1",      bus.inst1,    e_i1);
    endtask

    // Drive one cycle of stimulus, check the pre-edge outputs, then advance the model.
    task automatic apply_stimulus(input logic fl, input logic v0, input logic v1,
                                  input logic [31:0] pc0, input logic [31:0] i0,
                                  input logic [31:0] pc1, input logic [31:0] i1,
                                  input logic drdy);
        int     n;
        entry_t e;
        @(negedge clk);
        bus.flush           = fl;
        bus.fetch_inst0_val = v0;
        bus.fetch_inst1_val = v1;
        bus.fetch_inst0_pc  = pc0;
        bus.fetch_inst0     = i0;
        bus.fetch_inst1_pc  = pc1;
        bus.fetch_inst1     = i1;
        bus.decode_rdy      = drdy;
        #1;
        check_output();
        n = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (n > 0 && drdy) begin
                void'(model_q.pop_front());
                if (n > 1) void'(model_q.pop_front());
            end
            if ((DEPTH - n) >= 2 && v0) begin
                e.pc = pc0; e.inst = i0;
                model_q.push_back(e);
                if (v1) begin
                    e.pc = pc1; e.inst = i1;
                    model_q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input logic drdy);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, drdy);
    endtask

    task automatic push_pair(input logic [31:0] pc, input logic drdy);
        apply_stimulus(1'b0, 1'b1, 1'b1, pc, ins(pc), pc + 32'd4, ins(pc + 32'd4), drdy);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [31:0] pc;
        logic        rv0, rv1, rdr, rfl;

        vecs[0]  = '{1'b1, 1'b1, 32'h00, 32'h04, 1'b0, 0, 1'b1, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h08, 32'h0C, 1'b0, 2, 1'b1, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h10, 32'h14, 1'b0, 4, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 32'h18, 32'h1C, 1'b0, 6, 1'b1, 32'h00};
        vecs[4]  = '{1'b1, 1'b1, 32'h80, 32'h84, 1'b0, 8, 1'b0, 32'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h88, 32'h00, 1'b0, 8, 1'b0, 32'h00};
        vecs[6]  = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 8, 1'b0, 32'h00};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 6, 1'b1, 32'h08};
        vecs[8]  = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 4, 1'b1, 32'h10};
        vecs[9]  = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 2, 1'b1, 32'h18};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 0, 1'b1, 32'h00};

        rst_n = 1'b0;
        bus.flush = 1'b0; bus.fetch_inst0_val = 1'b0; bus.fetch_inst1_val = 1'b0;
        bus.fetch_inst0_pc = '0; bus.fetch_inst1_pc = '0;
        bus.fetch_inst0 = '0; bus.fetch_inst1 = '0; bus.decode_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check_output();
        rst_n = 1'b1;

        // Reset mid-run with five entries buffered.
        push_pair(32'h300, 1'b0);
        push_pair(32'h308, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h310, ins(32'h310), 32'd0, 32'd0, 1'b0);
        idle(1'b0);
        check("pre_reset_count", {28'd0, bus.ibuf_count}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_val",   {31'd0, bus.inst_val}, 32'd0);
        check("rst_async_rdy",   {31'd0, bus.ibuf_rdy}, 32'd1);
        check("rst_async_count", {28'd0, bus.ibuf_count}, 32'd0);
        check("rst_async_pc0",   bus.inst0_pc, 32'd0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h00500093, 32'h104, 32'h00a00113, 1'b0);
        idle(1'b0);
        check("post_reset_inst0", bus.inst0, 32'h00500093);
        check("post_reset_inst1", bus.inst1, 32'h00a00113);
        idle(1'b1);

        // Single instruction padded with a zero word.
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h200, 32'h00100093, 32'd0, 32'd0, 1'b0);
        idle(1'b1);
        check("pad_inst1",    bus.inst1,    32'd0);
        check("pad_inst1_pc", bus.inst1_pc, 32'h204);
        idle(1'b0);
        // Slot 1 without slot 0 must write nothing.
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h250, ins(32'h250), 1'b0);
        idle(1'b0);

        // Fill to full under back-pressure, then drain in order.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(1'b0, vecs[i].v0, vecs[i].v1, vecs[i].pc0, ins(vecs[i].pc0),
                           vecs[i].pc1, ins(vecs[i].pc1), vecs[i].drdy);
            check($sformatf("vec%0d_count", i), {28'd0, bus.ibuf_count}, vecs[i].exp_count);
            check($sformatf("vec%0d_rdy", i),   {31'd0, bus.ibuf_rdy},   {31'd0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_pc0", i),   bus.inst0_pc,            vecs[i].exp_pc0);
        end

        // Steady pair-in/pair-out traffic across the index wrap.
        push_pair(32'h400, 1'b0);
        push_pair(32'h408, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push_pair(32'h410 + 32'(8 * i), 1'b1);
            check($sformatf("wrap%0d_count", i), {28'd0, bus.ibuf_count}, 32'd4);
            check($sformatf("wrap%0d_pc0", i),   bus.inst0_pc, 32'h400 + 32'(8 * i));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Odd occupancy: pair in while a pair leaves keeps count at three.
        push_pair(32'h500, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h508, ins(32'h508), 32'd0, 32'd0, 1'b0);
        push_pair(32'h50C, 1'b1);
        idle(1'b0);
        check("odd_count", {28'd0, bus.ibuf_count}, 32'd3);
        check("odd_pc0",   bus.inst0_pc, 32'h508);
        check("odd_pc1",   bus.inst1_pc, 32'h50C);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Flush beats same-cycle enqueue and dequeue.
        push_pair(32'h600, 1'b0);
        push_pair(32'h608, 1'b0);
        push_pair(32'h610, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h700, ins(32'h700), 32'h704, ins(32'h704), 1'b1);
        idle(1'b0);
        check("flush_count", {28'd0, bus.ibuf_count}, 32'd0);
        check("flush_val",   {31'd0, bus.inst_val}, 32'd0);
        idle(1'b1);

        // Random mixed traffic against the reference queue.
        pc = 32'h1000;
        for (int i = 0; i < 80; i++) begin
            rv0 = ($urandom_range(0, 3) != 0);
            rv1 = ($urandom_range(0, 1) != 0);
            rdr = ($urandom_range(0, 2) != 0);
            rfl = ($urandom_range(0, 19) == 0);
            apply_stimulus(rfl, rv0, rv1, pc, ins(pc), pc + 32'd4, ins(pc + 32'd4), rdr);
            pc = pc + 32'd8;
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Circular instruction queue between fetch and decode. It accepts up to two instructions per cycle from fetch and presents them to decode as an in-order pair under decode's single-valid/ready handshake. When only one instruction is buffered, it pads the second slot with an all-zero word, which decode classifies as not valid. It decouples fetch-line delivery from rename back-pressure and clears on pipeline flush.

## Interface
- DEPTH, 8, number of entries; power of two, >= 4
- CPU_ADDR_BITS, CPU_INST_BITS: taken from uarch_pkg (32/32)
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- fetch_inst0_val  in  1  slot 0 from fetch is valid
- fetch_inst1_val  in  1  slot 1 from fetch is valid; meaningful only with fetch_inst0_val
- fetch_inst0_pc, fetch_inst1_pc  in  CPU_ADDR_BITS  PCs of the fetch slots
- fetch_inst0, fetch_inst1  in  CPU_INST_BITS  instruction words
- ibuf_rdy  out  1  buffer can take a full pair this cycle
- decode_rdy  in  1  decode accepts the presented pair
- inst0_pc, inst1_pc  out  CPU_ADDR_BITS  PCs presented to decode
- inst0, inst1  out  CPU_INST_BITS  instructions presented to decode
- inst_val  out  1  presented pair is valid
- ibuf_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: entry array {pc, inst} x DEPTH; head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH; count, $clog2(DEPTH)+1 bits. The entry array needs no reset.
- ibuf_rdy = (DEPTH - count) >= 2. It uses only the registered count and does not credit a same-cycle dequeue.
- Enqueue fires when ibuf_rdy && fetch_inst0_val && !flush.
  - Writes slot 0 at tail.
  - If fetch_inst1_val, also writes slot 1 at tail+1.
  - tail advances by 1 or 2 accordingly.
- fetch_inst1_val without fetch_inst0_val is a protocol violation. Nothing is written.
- Outputs are combinational from head and count:
  - inst_val = (count != 0).
  - count >= 2: inst0/inst0_pc from entry[head]; inst1/inst1_pc from entry[head+1].
  - count == 1: inst0/inst0_pc from entry[head]; inst1 = 0; inst1_pc = inst0_pc + 4.
  - count == 0: all output data = 0.
- Dequeue fires when inst_val && decode_rdy && !flush. It pops min(count, 2) entries and head advances by the same amount.
- count_next = count + enq_n - deq_n, where enq_n and deq_n are each in {0, 1, 2}. The result never exceeds DEPTH and never goes below 0.
- Flush has priority over enqueue and dequeue. On flush, head = tail = count = 0 at the next edge and same-cycle fetch data is discarded.
- Order is strict FIFO. Instructions are never reordered or duplicated.
- A single-instruction pop (count == 1) is final. A later instruction is never re-paired with an already-presented inst0.

## Timing
- Reset (rst_n low, asynchronous): head = tail = count = 0.
  - All outputs: inst_val = 0, ibuf_rdy = 1, ibuf_count = 0, and pc/inst outputs = 0.
  - These values hold while rst_n is low. Normal operation starts at the first rising edge after rst_n deasserts.
- Latency: data enqueued at edge N appears on the outputs in cycle N+1. There is no fetch-to-decode bypass.
- Output data is stable while inst_val && !decode_rdy. Only enqueue at tail can change state, and when count == 1 it can change inst1 from the pad to the real next instruction.
- Simultaneous enqueue and dequeue in one cycle are both applied at the same edge.
- Full condition: count >= DEPTH-1 gives ibuf_rdy = 0. Fetch must hold its data until ibuf_rdy = 1.
- Wrap-around: writes at tail = DEPTH-1 place slot 1 at index 0. Reads at head = DEPTH-1 take inst1 from index 0.
- Flush in the same cycle as a full buffer with decode_rdy: the buffer is empty next cycle and nothing is reported as dequeued.

## Test plan
- Reset then idle: hold rst_n low mid-run with count = 5.
  - Outputs go to 0 asynchronously and ibuf_rdy = 1.
  - After release, an enqueue of {0x100: 0x00500093, 0x104: 0x00a00113} gives inst_val = 1 with that pair in the following cycle.
- Single pad: enqueue only slot 0 (pc 0x200, inst 0x00100093).
  - Required output: inst_val = 1, inst1 = 0, inst1_pc = 0x204.
  - With decode_rdy = 1, count returns 0.
- Fill/back-pressure (DEPTH = 8) with decode_rdy = 0:
  - Four pair enqueues give count = 8 and ibuf_rdy = 0.
  - Enqueue attempts are ignored.
  - Releasing decode_rdy drains the pairs in PC order 0x0..0x1C.
- Wrap-around with concurrent traffic: enqueue and dequeue pairs every cycle for 20 cycles.
  - Count stays constant.
  - Output PCs increase by 8 per pop with no gaps across index DEPTH-1 to 0.
- Odd occupancy: count = 3, then enqueue a pair while dequeuing.
  - count becomes 3.
  - The next presented pair is the third old entry plus the first new one.
- Flush priority: count = 6, with flush, fetch_inst0_val and decode_rdy all high.
  - Next cycle: count = 0, inst_val = 0, and no fetch data is retained.
